// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encoding, header field layout and injector FSM states.
package noc_pkg;

  localparam int unsigned FLIT_W      = 32;
  localparam int unsigned FLIT_BODY_W = 30;
  localparam int unsigned COORD_W     = 6;
  localparam int unsigned LEN_W       = 3;
  localparam int unsigned CNT_W       = 4;

  localparam int unsigned HDR_DSTX_LSB = 24;
  localparam int unsigned HDR_DSTY_LSB = 18;
  localparam int unsigned HDR_SRCX_LSB = 12;
  localparam int unsigned HDR_SRCY_LSB = 6;
  localparam int unsigned HDR_LEN_LSB  = 3;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e               ftype;
    logic [FLIT_BODY_W-1:0]   body;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } inj_state_e;

  // Header body: dst_x | dst_y | src_x | src_y | len | 3'b000
  function automatic logic [FLIT_BODY_W-1:0] make_hdr_body(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [LEN_W-1:0]   len
  );
    logic [FLIT_BODY_W-1:0] b;
    b = '0;
    b[HDR_DSTX_LSB +: COORD_W] = dst_x;
    b[HDR_DSTY_LSB +: COORD_W] = dst_y;
    b[HDR_SRCX_LSB +: COORD_W] = src_x;
    b[HDR_SRCY_LSB +: COORD_W] = src_y;
    b[HDR_LEN_LSB  +: LEN_W]   = len;
    return b;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating credit counter toward the router input buffer, with sticky overflow flag.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next_c,
  output logic             credit_err
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Simultaneous return and send cancel; a return at full count is a protocol error.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({inc, dec})
      2'b10: begin
        if (count_q == CNT_W'(CREDITS)) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_W'(CREDITS);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count        = count_q;
  assign count_next_c = count_d;
  assign credit_err   = err_q;

endmodule

// File: rtl/noc_flit_injector.sv
// Packetises a descriptor plus payload stream into HEAD/BODY/TAIL flits under credit flow control.
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int unsigned   X_W     = 6,
  parameter int unsigned   Y_W     = 6,
  parameter logic [X_W-1:0] SRC_X  = '0,
  parameter logic [Y_W-1:0] SRC_Y  = '0,
  parameter int unsigned   CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [X_W-1:0]         msg_dst_x,
  input  logic [Y_W-1:0]         msg_dst_y,
  input  logic [LEN_W-1:0]       msg_len,
  input  logic                   pld_valid,
  output logic                   pld_ready,
  input  logic [FLIT_BODY_W-1:0] pld_data,
  output logic                   flit_valid,
  output logic [FLIT_W-1:0]      flit_data,
  input  logic                   credit_in,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   credit_err
);

  inj_state_e       state_q, state_d;
  logic [X_W-1:0]   dst_x_q, dst_x_d;
  logic [Y_W-1:0]   dst_y_q, dst_y_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             msg_ready_q, msg_ready_d;
  logic             pld_ready_q, pld_ready_d;
  logic             busy_q, busy_d;
  logic             flit_valid_q, flit_valid_d;
  flit_t            flit_q, flit_d;
  logic             pkt_done_q, pkt_done_d;
  logic             send;
  logic [CNT_W-1:0] credits, credits_next;

  noc_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (credit_in),
    .dec          (send),
    .count        (credits),
    .count_next_c (credits_next),
    .credit_err   (credit_err)
  );

  // Next-state, flit assembly and registered handshake outputs.
  always_comb begin
    state_d      = state_q;
    dst_x_d      = dst_x_q;
    dst_y_d      = dst_y_q;
    len_d        = len_q;
    beat_d       = beat_q;
    flit_valid_d = 1'b0;
    flit_d       = '0;
    pkt_done_d   = 1'b0;
    send         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (msg_valid && msg_ready_q) begin
          dst_x_d = msg_dst_x;
          dst_y_d = msg_dst_y;
          len_d   = msg_len;
          beat_d  = '0;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (credits != '0) begin
          send         = 1'b1;
          flit_valid_d = 1'b1;
          flit_d.ftype = FLIT_HEAD;
          flit_d.body  = make_hdr_body(COORD_W'(dst_x_q), COORD_W'(dst_y_q),
                                       COORD_W'(SRC_X), COORD_W'(SRC_Y), len_q);
          state_d      = ST_BODY;
        end
      end
      ST_BODY: begin
        if (pld_valid && pld_ready_q) begin
          send         = 1'b1;
          flit_valid_d = 1'b1;
          flit_d.body  = pld_data;
          if (beat_q == len_q) begin
            flit_d.ftype = FLIT_TAIL;
            pkt_done_d   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            flit_d.ftype = FLIT_BODY;
            beat_d       = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready flags track the upcoming state so they are valid in the cycle they are seen.
    msg_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    pld_ready_d = (state_d == ST_BODY) && (credits_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      msg_ready_q  <= 1'b0;
      pld_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dst_x_q      <= dst_x_d;
      dst_y_q      <= dst_y_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      msg_ready_q  <= msg_ready_d;
      pld_ready_q  <= pld_ready_d;
      busy_q       <= busy_d;
      flit_valid_q <= flit_valid_d;
      flit_q       <= flit_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign msg_ready  = msg_ready_q;
  assign pld_ready  = pld_ready_q;
  assign busy       = busy_q;
  assign flit_valid = flit_valid_q;
  assign flit_data  = flit_q;
  assign pkt_done   = pkt_done_q;

endmodule
